// File: rtl/audio_receive_stereo.sv
`default_nettype none
// ============================================================================
// Module   : audio_receive_stereo
// Function : I2S / left-justified serial ADC receiver producing a coherent
//            MSB-aligned left/right sample pair with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module audio_receive_stereo #(
  parameter int WL       = 24,
  parameter int DW       = 32,
  parameter bit I2S_MODE = 1'b1,
  parameter bit LEFT_LVL = 1'b0
) (
  input  logic          aud_bclk,
  input  logic          rst_n,
  input  logic          aud_lrc,
  input  logic          aud_adcdat,
  output logic [DW-1:0] out_left,
  output logic [DW-1:0] out_right,
  output logic          rx_valid,
  output logic          frame_err
);

  localparam int              c_cnt_w    = $clog2(WL + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WL);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WL - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_lrc_d;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WL-2:0]      r_sh;
  logic               r_chan_left;
  logic               r_left_ok;
  logic [DW-1:0]      r_left_hold;

  logic               w_edge;
  logic               w_take;
  logic               w_complete;
  logic               w_short;
  logic [WL-1:0]      w_sample;
  logic [DW-1:0]      w_wide;

  always_comb begin
    w_edge     = aud_lrc ^ r_lrc_d;
    w_take     = (r_cnt < c_cnt_full);
    w_sample   = {r_sh, aud_adcdat};
    w_wide     = DW'(w_sample) << (DW - WL);
    // In I2S the edge-cycle bit is still the old slot's LSB; in LJ it is the new MSB.
    w_complete = (r_cnt == c_cnt_last) && ((I2S_MODE != 1'b0) || !w_edge);
    w_short    = w_edge && ((I2S_MODE != 1'b0) ? (r_cnt < c_cnt_last) : w_take);
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrc_d     <= 1'b0;
      r_cnt       <= c_cnt_full;
      r_sh        <= '0;
      r_chan_left <= 1'b0;
      r_left_ok   <= 1'b0;
      r_left_hold <= '0;
      out_left    <= '0;
      out_right   <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_lrc_d   <= aud_lrc;
      rx_valid  <= 1'b0;
      frame_err <= w_short;

      if (w_edge || w_take) begin
        r_sh <= w_sample[WL-2:0];
      end

      if (w_edge) begin
        r_chan_left <= (aud_lrc == LEFT_LVL);
        r_cnt       <= (I2S_MODE != 1'b0) ? '0 : c_cnt_one;
      end else if (w_take) begin
        r_cnt <= r_cnt + c_cnt_one;
      end

      // r_chan_left still names the finishing slot on an I2S edge cycle.
      if (w_complete) begin
        if (r_chan_left) begin
          r_left_hold <= w_wide;
          r_left_ok   <= 1'b1;
        end else if (r_left_ok) begin
          out_left  <= r_left_hold;
          out_right <= w_wide;
          rx_valid  <= 1'b1;
          r_left_ok <= 1'b0;
        end
      end

      if (w_short) begin
        r_left_ok <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_receive_stereo.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_receive_stereo
// Function : Drives an I2S and a left-justified receiver with the same frames
//            and compares both against a slot-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_receive_stereo;

  localparam int WL       = 24;
  localparam int DW       = 32;
  localparam bit LEFT_LVL = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic lrc   = 1'b0;
  logic d_lj  = 1'b0;
  logic d_i2s = 1'b0;
  logic lj_prev = 1'b0;

  logic [DW-1:0] lj_l, lj_r, is_l, is_r;
  logic          lj_v, lj_e, is_v, is_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // index 0 = left-justified DUT, index 1 = I2S DUT
  logic          md_prev  [2];
  bit            md_active[2];
  bit            md_left  [2];
  bit            md_ok    [2];
  int            md_n     [2];
  logic [WL-1:0] md_bits  [2];
  logic [DW-1:0] md_hold  [2];
  logic [DW-1:0] ex_l     [2];
  logic [DW-1:0] ex_r     [2];
  logic          ex_v     [2];
  logic          ex_e     [2];
  int            err_cnt  [2];

  logic [DW-1:0] cap_l0[$], cap_r0[$], cap_l1[$], cap_r1[$];

  typedef struct {
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    int            len_l;
    int            len_r;
    bit            good;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  audio_receive_stereo #(.WL(WL), .DW(DW), .I2S_MODE(1'b0), .LEFT_LVL(LEFT_LVL)) u_lj (
    .aud_bclk(clk), .rst_n(rst_n), .aud_lrc(lrc), .aud_adcdat(d_lj),
    .out_left(lj_l), .out_right(lj_r), .rx_valid(lj_v), .frame_err(lj_e));

  audio_receive_stereo #(.WL(WL), .DW(DW), .I2S_MODE(1'b1), .LEFT_LVL(LEFT_LVL)) u_i2s (
    .aud_bclk(clk), .rst_n(rst_n), .aud_lrc(lrc), .aud_adcdat(d_i2s),
    .out_left(is_l), .out_right(is_r), .rx_valid(is_v), .frame_err(is_e));

  task automatic model_reset(input int m);
    md_prev[m] = 1'b0; md_active[m] = 0; md_left[m] = 0; md_ok[m] = 0;
    md_n[m] = 0; md_bits[m] = '0; md_hold[m] = '0;
    ex_l[m] = '0; ex_r[m] = '0; ex_v[m] = 1'b0; ex_e[m] = 1'b0;
  endtask

  task automatic finish_slot(input int m);
    logic [DW-1:0] word;
    word = {md_bits[m], {(DW-WL){1'b0}}};
    if (md_left[m]) begin
      md_hold[m] = word;
      md_ok[m]   = 1;
    end else if (md_ok[m]) begin
      ex_l[m] = md_hold[m];
      ex_r[m] = word;
      ex_v[m] = 1'b1;
      md_ok[m] = 0;
    end
  endtask

  task automatic add_bit(input int m, input logic d);
    md_bits[m] = {md_bits[m][WL-2:0], d};
    md_n[m]++;
    if (md_n[m] == WL) finish_slot(m);
  endtask

  // Slot-level view: an LRC change closes the old slot, which is either
  // complete (WL bits seen), finishing with this bit (I2S), or short.
  task automatic model_step(input int m, input logic lv, input logic d);
    bit edge_seen;
    edge_seen = (lv != md_prev[m]);
    ex_v[m] = 1'b0;
    ex_e[m] = 1'b0;
    if (edge_seen) begin
      if (md_active[m] && md_n[m] < WL) begin
        if (m == 1 && md_n[m] == WL - 1) begin
          add_bit(m, d);
        end else begin
          ex_e[m]  = 1'b1;
          md_ok[m] = 0;
        end
      end
      md_active[m] = 1;
      md_left[m]   = (lv == LEFT_LVL);
      md_n[m]      = 0;
      md_bits[m]   = '0;
      if (m == 0) add_bit(m, d);
    end else if (md_active[m] && md_n[m] < WL) begin
      add_bit(m, d);
    end
    md_prev[m] = lv;
  endtask

  task automatic check_mode(input int m, input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic v, input logic e);
    checks++;
    if (l !== ex_l[m] || r !== ex_r[m] || v !== ex_v[m] || e !== ex_e[m]) begin
      errors++;
      $display("FAIL cycle %0d mode %s outputs: got L=%h R=%h v=%b e=%b, want L=%h R=%h v=%b e=%b",
               cyc, (m == 1) ? "i2s" : "lj", l, r, v, e, ex_l[m], ex_r[m], ex_v[m], ex_e[m]);
    end
    if (v === 1'b1) begin
      if (m == 0) begin cap_l0.push_back(l); cap_r0.push_back(r); end
      else        begin cap_l1.push_back(l); cap_r1.push_back(r); end
    end
    if (e === 1'b1) err_cnt[m]++;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic tick(input logic lv, input logic d);
    @(negedge clk);
    lrc     = lv;
    d_lj    = d;
    d_i2s   = lj_prev;
    lj_prev = d;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, lrc, d_lj);
      model_step(1, lrc, d_i2s);
    end
    #1;
    check_mode(0, lj_l, lj_r, lj_v, lj_e);
    check_mode(1, is_l, is_r, is_v, is_e);
  endtask

  task automatic send_slot(input logic lv, input logic [WL-1:0] s, input int len);
    for (int k = 0; k < len; k++) begin
      tick(lv, (k < WL) ? s[WL-1-k] : logic'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [WL-1:0] l, input logic [WL-1:0] r,
                            input int len_l, input int len_r);
    send_slot(LEFT_LVL, l, len_l);
    send_slot(~LEFT_LVL, r, len_r);
  endtask

  initial begin
    int b0, b1, gi;
    model_reset(0);
    model_reset(1);
    err_cnt[0] = 0;
    err_cnt[1] = 0;

    tbl[0] = '{24'hABCDEF, 24'h123456, 32, 32, 1'b1, 32'hABCDEF00, 32'h12345600};
    tbl[1] = '{24'h800001, 24'h7FFFFE, 24, 24, 1'b1, 32'h80000100, 32'h7FFFFE00};
    tbl[2] = '{24'h0F0F0F, 24'hF0F0F0, 32, 32, 1'b1, 32'h0F0F0F00, 32'hF0F0F000};
    tbl[3] = '{24'h111111, 24'h222222, 16, 32, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{24'h5A5A5A, 24'hA5A5A5, 32, 32, 1'b1, 32'h5A5A5A00, 32'hA5A5A500};
    tbl[5] = '{24'hFFFFFF, 24'h000000, 25, 31, 1'b1, 32'hFFFFFF00, 32'h00000000};
    tbl[6] = '{24'h000001, 24'h800000, 32, 24, 1'b1, 32'h00000100, 32'h80000000};

    repeat (3) tick(LEFT_LVL, 1'b1);
    chk("reset out_left lj", lj_l, '0);
    chk("reset out_right i2s", is_r, '0);
    rst_n = 1'b1;

    // Startup on a right slot: completes but must not pulse.
    send_slot(~LEFT_LVL, 24'hC0FFEE, 32);
    b0 = cap_l0.size();
    b1 = cap_l1.size();

    foreach (tbl[i]) send_frame(tbl[i].l, tbl[i].r, tbl[i].len_l, tbl[i].len_r);
    send_slot(LEFT_LVL, 24'h3C3C3C, 32);

    chk("pairs lj", DW'(cap_l0.size() - b0), DW'(6));
    chk("pairs i2s", DW'(cap_l1.size() - b1), DW'(6));
    chk("frame_err lj", DW'(err_cnt[0]), DW'(1));
    chk("frame_err i2s", DW'(err_cnt[1]), DW'(1));
    gi = 0;
    foreach (tbl[i]) begin
      if (tbl[i].good) begin
        chk("tbl left lj",   (b0 + gi < cap_l0.size()) ? cap_l0[b0+gi] : 'x, tbl[i].el);
        chk("tbl right lj",  (b0 + gi < cap_r0.size()) ? cap_r0[b0+gi] : 'x, tbl[i].er);
        chk("tbl left i2s",  (b1 + gi < cap_l1.size()) ? cap_l1[b1+gi] : 'x, tbl[i].el);
        chk("tbl right i2s", (b1 + gi < cap_r1.size()) ? cap_r1[b1+gi] : 'x, tbl[i].er);
        gi++;
      end
    end

    send_slot(~LEFT_LVL, 24'h0, 32);
    for (int f = 0; f < 40; f++) begin
      send_frame(WL'($urandom), WL'($urandom), $urandom_range(14, 36), $urandom_range(14, 36));
    end

    // Asynchronous reset in the middle of a left slot.
    send_slot(LEFT_LVL, 24'h9ABCDE, 10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("async rst left lj", lj_l, '0);
    chk("async rst right i2s", is_r, '0);
    chk("async rst valid i2s", DW'(is_v), '0);
    repeat (22) tick(LEFT_LVL, 1'b1);
    repeat (5) tick(~LEFT_LVL, 1'b0);
    rst_n = 1'b1;
    send_slot(~LEFT_LVL, 24'h654321, 27);
    b0 = cap_l0.size();
    b1 = cap_l1.size();
    chk("no pair before L/R lj", DW'(b0), DW'(cap_l0.size()));
    send_frame(24'h13579B, 24'h2468AC, 32, 32);
    chk("recovery pairs lj", DW'(cap_l0.size() - b0), DW'(1));
    chk("recovery pairs i2s", DW'(cap_l1.size() - b1), DW'(1));
    chk("recovery left i2s", is_l, 32'h13579B00);
    chk("recovery right i2s", is_r, 32'h2468AC00);
    chk("recovery left lj", lj_l, 32'h13579B00);
    chk("recovery right lj", lj_r, 32'h2468AC00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
